// File: rtl/alu16_pkg.sv
// Shared encodings for the 16-bit execute/memory stage: ALUOp codes,
// ALU control words, R-type funct codes and I-type opcodes.
package alu16_pkg;

  // ALUOp field produced by the main control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // load/store address
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode funct
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;  // decode opcode

  // ALU operation field (ALUCtrl[2:0])
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SLT = 3'b011,
    OP_XOR = 3'b100,
    OP_NOR = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } alu_op_e;

  // Full 4-bit control words: bit 3 is Binvert
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b1010;
  localparam logic [3:0] CTRL_SLT = 4'b1011;
  localparam logic [3:0] CTRL_XOR = 4'b0100;
  localparam logic [3:0] CTRL_NOR = 4'b0101;
  localparam logic [3:0] CTRL_SLL = 4'b0110;
  localparam logic [3:0] CTRL_SRL = 4'b0111;

  // R-type funct codes (instruction[3:0])
  localparam logic [3:0] FUNCT_AND = 4'b0000;
  localparam logic [3:0] FUNCT_OR  = 4'b0001;
  localparam logic [3:0] FUNCT_ADD = 4'b0010;
  localparam logic [3:0] FUNCT_SUB = 4'b0011;
  localparam logic [3:0] FUNCT_SLT = 4'b0100;
  localparam logic [3:0] FUNCT_XOR = 4'b0101;
  localparam logic [3:0] FUNCT_NOR = 4'b0110;
  localparam logic [3:0] FUNCT_SLL = 4'b0111;
  localparam logic [3:0] FUNCT_SRL = 4'b1000;

  // I-type opcodes (instruction[15:13])
  localparam logic [2:0] OPC_ADDI = 3'b100;
  localparam logic [2:0] OPC_SLTI = 3'b101;
  localparam logic [2:0] OPC_ANDI = 3'b110;
  localparam logic [2:0] OPC_ORI  = 3'b111;

  // Flag bundle leaving the ALU
  typedef struct packed {
    logic zero;
    logic overflow;
    logic carry;
  } alu_flags_t;

endpackage

// File: rtl/alu_ctrl_alu16_dmem_dmem_array.sv
// dmem_array: word-addressed data memory with synchronous write,
// synchronous full clear on Reset and combinational, gated read.
// A read of the word being written returns the pre-write contents.
module dmem_array #(
  parameter int ADDR_W = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              write_en,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       write_data,
  output logic [15:0]       read_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [15:0] mem [DEPTH];

  // Clear every word on Reset (wins over a same-cycle write), else store
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 16'h0000;
      end
    end else if (write_en) begin
      mem[addr] <= write_data;
    end
  end

  // Combinational read, forced to zero when not enabled
  always_comb begin
    read_data = 16'h0000;
    if (read_en) begin
      read_data = mem[addr];
    end
  end

endmodule

// File: rtl/alu_ctrl_alu16_dmem.sv
// alu_ctrl_alu16_dmem: execute/memory stage of the 16-bit datapath.
// Decodes ALUOp/Funct/Opcode into a 4-bit ALU control word, runs the
// 16-bit ALU (zero/overflow/carry flags) and accesses data memory at
// the ALU result (byte address of 16-bit words).
// Optional feature macro: ALU16_SHIFT_EN enables SLL/SRL; without it
// shift funct codes decode to ADD and ALU ops 110/111 return zero.
module alu_ctrl_alu16_dmem
  import alu16_pkg::*;
#(
  parameter int DEPTH_LOG2 = 7
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  ALUOp,
  input  logic [3:0]  Funct,
  input  logic [2:0]  Opcode,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic [15:0] ALUResult,
  output logic        Zero,
  output logic        Overflow,
  output logic        CarryOut,
  output logic [15:0] ReadData
);

  logic [3:0]  ctrl;
  logic        binvert;
  alu_op_e     op;
  logic [15:0] bx;
  logic [16:0] sum;
  logic        add_ovf;
  logic [15:0] result;
  alu_flags_t  flags;
  logic [DEPTH_LOG2-1:0] word_index;

  // ALU control decode from ALUOp, then Funct (R-type) or Opcode (I-type)
  always_comb begin
    ctrl = CTRL_ADD;
    case (ALUOp)
      ALUOP_ADD: ctrl = CTRL_ADD;
      ALUOP_SUB: ctrl = CTRL_SUB;
      ALUOP_RTYPE: begin
        case (Funct)
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_OR:  ctrl = CTRL_OR;
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_SLT: ctrl = CTRL_SLT;
          FUNCT_XOR: ctrl = CTRL_XOR;
          FUNCT_NOR: ctrl = CTRL_NOR;
`ifdef ALU16_SHIFT_EN
          FUNCT_SLL: ctrl = CTRL_SLL;
          FUNCT_SRL: ctrl = CTRL_SRL;
`endif
          default:   ctrl = CTRL_ADD;
        endcase
      end
      ALUOP_ITYPE: begin
        case (Opcode)
          OPC_ADDI: ctrl = CTRL_ADD;
          OPC_SLTI: ctrl = CTRL_SLT;
          OPC_ANDI: ctrl = CTRL_AND;
          OPC_ORI:  ctrl = CTRL_OR;
          default:  ctrl = CTRL_ADD;
        endcase
      end
      default: ctrl = CTRL_ADD;
    endcase
  end

  assign ALUCtrl = ctrl;
  assign binvert = ctrl[3];
  assign op      = alu_op_e'(ctrl[2:0]);

  // Shared adder: subtract is A + ~B + 1 using Binvert as carry-in
  assign bx      = B ^ {16{binvert}};
  assign sum     = {1'b0, A} + {1'b0, bx} + {16'h0000, binvert};
  assign add_ovf = (A[15] == bx[15]) && (sum[15] != A[15]);

  // ALU result and flags; only ADD and SLT report carry/overflow
  always_comb begin
    result         = 16'h0000;
    flags.carry    = 1'b0;
    flags.overflow = 1'b0;
    case (op)
      OP_AND: result = A & bx;
      OP_OR:  result = A | bx;
      OP_ADD: begin
        result         = sum[15:0];
        flags.carry    = sum[16];
        flags.overflow = add_ovf;
      end
      OP_SLT: begin
        // Sign of the true difference: sum sign corrected by overflow
        result         = {15'h0000, sum[15] ^ add_ovf};
        flags.carry    = sum[16];
        flags.overflow = add_ovf;
      end
      OP_XOR: result = A ^ B;
      OP_NOR: result = ~(A | B);
`ifdef ALU16_SHIFT_EN
      OP_SLL: result = A << B[3:0];
      OP_SRL: result = A >> B[3:0];
`else
      OP_SLL: result = 16'h0000;
      OP_SRL: result = 16'h0000;
`endif
      default: result = 16'h0000;
    endcase
    flags.zero = (result == 16'h0000);
  end

  assign ALUResult = result;
  assign Zero      = flags.zero;
  assign Overflow  = flags.overflow;
  assign CarryOut  = flags.carry;

  // Byte address -> word index: drop bit 0, ignore bits above the depth
  assign word_index = result[DEPTH_LOG2:1];

  dmem_array #(
    .ADDR_W (DEPTH_LOG2)
  ) u_dmem (
    .Clock      (Clock),
    .Reset      (Reset),
    .write_en   (MemWrite),
    .read_en    (MemRead),
    .addr       (word_index),
    .write_data (WriteData),
    .read_data  (ReadData)
  );

endmodule

// File: tb/tb_alu_ctrl_alu16_dmem.sv
// Testbench for alu_ctrl_alu16_dmem: directed test-plan steps followed by
// randomized ALU and memory traffic checked against a behavioural model.
module tb_alu_ctrl_alu16_dmem;

  localparam int DL    = 7;
  localparam int WORDS = 1 << DL;

  logic        Clock;
  logic        Reset;
  logic [1:0]  ALUOp;
  logic [3:0]  Funct;
  logic [2:0]  Opcode;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [3:0]  ALUCtrl;
  logic [15:0] ALUResult;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;
  logic [15:0] ReadData;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_mem [WORDS];
  logic [15:0] exp_q[$];
  int          last_idx;

  alu_ctrl_alu16_dmem #(.DEPTH_LOG2(DL)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .ALUOp     (ALUOp),
    .Funct     (Funct),
    .Opcode    (Opcode),
    .A         (A),
    .B         (B),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ALUCtrl   (ALUCtrl),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .Overflow  (Overflow),
    .CarryOut  (CarryOut),
    .ReadData  (ReadData)
  );

  // Clock and reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference control table straight from the instruction encoding
  function automatic logic [3:0] model_ctrl(input logic [1:0] aop, input logic [3:0] f,
                                            input logic [2:0] opc);
    logic [3:0] c;
    c = 4'b0010;
    if (aop == 2'b01) c = 4'b1010;
    else if (aop == 2'b10) begin
      case (f)
        4'd0: c = 4'b0000;
        4'd1: c = 4'b0001;
        4'd3: c = 4'b1010;
        4'd4: c = 4'b1011;
        4'd5: c = 4'b0100;
        4'd6: c = 4'b0101;
`ifdef ALU16_SHIFT_EN
        4'd7: c = 4'b0110;
        4'd8: c = 4'b0111;
`endif
        default: c = 4'b0010;
      endcase
    end else if (aop == 2'b11) begin
      case (opc)
        3'd5: c = 4'b1011;
        3'd6: c = 4'b0000;
        3'd7: c = 4'b0001;
        default: c = 4'b0010;
      endcase
    end
    return c;
  endfunction

  // Reference ALU using integer arithmetic on signed/unsigned values
  task automatic model_alu(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic cy, output logic ov);
    int sa, sb, s;
    logic [15:0] bb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    bb = c[3] ? ~b : b;
    r = 16'h0000; cy = 1'b0; ov = 1'b0;
    case (c[2:0])
      3'd0: r = a & bb;
      3'd1: r = a | bb;
      3'd2, 3'd3: begin
        if (c[3]) begin
          s  = sa - sb;
          cy = (a >= b);
          r  = a - b;
        end else begin
          s  = sa + sb;
          cy = ((int'(a) + int'(b)) > 65535);
          r  = a + b;
        end
        ov = (s > 32767) || (s < -32768);
        if (c[2:0] == 3'd3) r = (s < 0) ? 16'h0001 : 16'h0000;
      end
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
`ifdef ALU16_SHIFT_EN
      3'd6: r = a << b[3:0];
      3'd7: r = a >> b[3:0];
`endif
      default: r = 16'h0000;
    endcase
  endtask

  // Compare every output against the model for the current inputs
  task automatic check_model();
    logic [3:0]  ec;
    logic [15:0] er;
    logic        ecy, eov;
    ec = model_ctrl(ALUOp, Funct, Opcode);
    model_alu(ec, A, B, er, ecy, eov);
    last_idx = int'(er >> 1) % WORDS;
    exp_q.push_back(MemRead ? model_mem[last_idx] : 16'h0000);
    check("alu_ctrl", {12'h000, ALUCtrl}, {12'h000, ec});
    check("alu_result", ALUResult, er);
    check("zero", {15'h0, Zero}, {15'h0, er == 16'h0000});
    check("overflow", {15'h0, Overflow}, {15'h0, eov});
    check("carry", {15'h0, CarryOut}, {15'h0, ecy});
    check("read_data", ReadData, exp_q.pop_front());
  endtask

  // Driver: apply inputs on the falling edge, then check after settling
  task automatic drive(input logic [1:0] aop, input logic [3:0] f, input logic [2:0] opc,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] wd,
                       input logic mr, input logic mw, input logic rst);
    @(negedge Clock);
    ALUOp = aop; Funct = f; Opcode = opc; A = a; B = b;
    WriteData = wd; MemRead = mr; MemWrite = mw; Reset = rst;
    #1;
    check_model();
  endtask

  // Advance through the rising edge and update the memory model
  task automatic tick();
    @(posedge Clock);
    if (Reset) begin
      for (int i = 0; i < WORDS; i++) model_mem[i] = 16'h0000;
    end else if (MemWrite) begin
      model_mem[last_idx] = WriteData;
    end
  endtask

  initial begin
    ALUOp = 2'b00; Funct = 4'h0; Opcode = 3'h0; A = 16'h0; B = 16'h0;
    WriteData = 16'h0; MemRead = 1'b0; MemWrite = 1'b0; Reset = 1'b1;
    for (int i = 0; i < WORDS; i++) model_mem[i] = 16'hxxxx;

    // Reset, then memory reads zero anywhere
    drive(2'b00, 4'h0, 3'h0, 16'h0000, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b1); tick();
    drive(2'b00, 4'h0, 3'h0, 16'h0000, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0);
    check("reset_read0", ReadData, 16'h0000); tick();
    drive(2'b00, 4'h0, 3'h0, 16'h00F0, 16'h000E, 16'h0, 1'b1, 1'b0, 1'b0);
    check("reset_read_fe", ReadData, 16'h0000); tick();

    // SUB equal operands
    drive(2'b10, 4'b0011, 3'h0, 16'h0005, 16'h0005, 16'h0, 1'b0, 1'b0, 1'b0);
    check("sub_ctrl", {12'h0, ALUCtrl}, 16'h000A);
    check("sub_res", ALUResult, 16'h0000);
    check("sub_flags", {13'h0, Zero, CarryOut, Overflow}, 16'h0006); tick();

    // ADD signed overflow
    drive(2'b10, 4'b0010, 3'h0, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0);
    check("add_ovf_res", ALUResult, 16'h8000);
    check("add_ovf_flags", {14'h0, Overflow, CarryOut}, 16'h0002); tick();

    // SLTI
    drive(2'b11, 4'h0, 3'b101, 16'hFFFE, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0);
    check("slti_ctrl", {12'h0, ALUCtrl}, 16'h000B);
    check("slti_neg", ALUResult, 16'h0001); tick();
    drive(2'b11, 4'h0, 3'b101, 16'h0003, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0);
    check("slti_pos", ALUResult, 16'h0000); tick();

    // Shift funct
    drive(2'b10, 4'b0111, 3'h0, 16'h0003, 16'h0004, 16'h0, 1'b0, 1'b0, 1'b0);
`ifdef ALU16_SHIFT_EN
    check("sll_res", ALUResult, 16'h0030);
`else
    check("sll_off_ctrl", {12'h0, ALUCtrl}, 16'h0002);
    check("sll_off_res", ALUResult, 16'h0007);
`endif
    tick();

    // Store with same-cycle read, then read back
    drive(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'hBEEF, 1'b1, 1'b1, 1'b0);
    check("rdw_old", ReadData, 16'h0000); tick();
    drive(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'h0, 1'b1, 1'b0, 1'b0);
    check("store_read", ReadData, 16'hBEEF); tick();
    drive(2'b00, 4'h0, 3'h0, 16'h0011, 16'h0004, 16'h0, 1'b1, 1'b0, 1'b0);
    check("byte_bit0", ReadData, 16'hBEEF); tick();

    // Reset beats a same-cycle write
    drive(2'b00, 4'h0, 3'h0, 16'h0002, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b0); tick();
    drive(2'b00, 4'h0, 3'h0, 16'h0002, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0);
    check("pre_reset", ReadData, 16'h1234); tick();
    drive(2'b00, 4'h0, 3'h0, 16'h0002, 16'h0000, 16'h5555, 1'b0, 1'b1, 1'b1); tick();
    drive(2'b00, 4'h0, 3'h0, 16'h0002, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0);
    check("reset_wins", ReadData, 16'h0000); tick();
    drive(2'b00, 4'h0, 3'h0, 16'h0010, 16'h0004, 16'h0, 1'b0, 1'b0, 1'b0);
    check("read_gated", ReadData, 16'h0000); tick();

    // Random ALU traffic across all decode paths
    for (int n = 0; n < 300; n++) begin
      drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), 1'b0, 1'b0);
      tick();
    end

    // Random memory traffic on a narrow address window, including wrap
    for (int n = 0; n < 300; n++) begin
      drive(2'b00, 4'h0, 3'h0, 16'($urandom_range(0, 40) + (($urandom_range(0, 1)) << 8)),
            16'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
